// File: rtl/des_pkg.sv
// des_pkg: constants and helpers shared by the DES key-schedule slice.
//
// Contents:
//   PC1[1:56]    - permuted choice 1. Maps the 64-bit key to C0||D0 and drops the parity bits.
//   PC2[1:48]    - permuted choice 2. Maps C||D (56 bits) to a 48-bit round subkey.
//   SHIFTS[1:16] - left-rotate amount applied to C and D before each encrypt round.
//   state_t      - key-schedule FSM encoding (IDLE, ACTIVE).
//   shift_amt()  - SHIFTS lookup that is safe for out-of-range round values.
//   rot_left() / rot_right() - rotate a 28-bit half by 1 or 2 places.
//
// Bit numbering follows the DES standard: bit 1 is the most significant bit.
package des_pkg;

    localparam int PC1 [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFTS [1:16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // A round number outside 1..16 never occurs while ACTIVE.
    // The loop keeps the lookup free of out-of-range array indexing.
    function automatic int shift_amt(input logic [4:0] rnd);
        int amt;
        amt = 1;
        for (int i = 1; i <= 16; i++) begin
            if (rnd == i[4:0]) begin
                amt = SHIFTS[i];
            end
        end
        return amt;
    endfunction

    // Rotate left: bit 2 moves into position 1, and bit 1 wraps to position 28.
    function automatic logic [1:28] rot_left(input logic [1:28] v, input int n);
        logic [1:28] r;
        if (n == 2) begin
            r = {v[3:28], v[1:2]};
        end else begin
            r = {v[2:28], v[1]};
        end
        return r;
    endfunction

    // Rotate right: the exact inverse of rot_left for the same n.
    function automatic logic [1:28] rot_right(input logic [1:28] v, input int n);
        logic [1:28] r;
        if (n == 2) begin
            r = {v[27:28], v[1:26]};
        end else begin
            r = {v[28], v[1:27]};
        end
        return r;
    endfunction

endpackage

// File: rtl/pc2_permutation.sv
// pc2_permutation: DES permuted choice 2. Pure combinational logic.
//
// Ports:
//   data_i [1:56] - C||D halves from the key schedule
//   data_o [1:48] - round subkey Kn
module pc2_permutation
    import des_pkg::*;
(
    input  logic [1:56] data_i,
    output logic [1:48] data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 1; i <= 48; i++) begin
            data_o[i] = data_i[PC2[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: produces the sixteen 48-bit DES round subkeys, one per round.
//
// Operation:
//   - On start, the key is latched through PC-1 into C||D.
//   - On each next, C and D are rotated.
//   - The current subkey is kn = PC-2(C||D). It is combinational from the registered halves.
//   - Encrypt order is K1..K16. Decrypt order is K16..K1. The direction is sampled with start.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous, active-high reset
//   start    - one-cycle pulse; key and decrypt are valid. Honoured only while idle.
//   key      - 64-bit DES key. Parity bits 8,16,..,64 are ignored.
//   decrypt  - sampled with start; 0 = K1..K16, 1 = K16..K1
//   next     - the consumer has used the current kn; advance
//   kn       - current subkey, valid while kn_valid = 1
//   round    - current round number 1..16 in use order; 0 when idle
//   kn_valid - kn/round hold a valid subkey
//   busy     - a schedule is in progress
//   done     - one-cycle pulse after the last subkey is consumed
//
// Handshake: kn_valid/next form a valid/ready pair.
//   - A subkey transfers on a rising edge where kn_valid and next are both 1.
//   - While kn_valid = 1 and next = 0, kn and round hold steady indefinitely.
//   - next is ignored when kn_valid = 0.
//   - After a transfer the following subkey appears with no bubble.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:64] key,
    input  logic        decrypt,
    input  logic        next,
    output logic [1:48] kn,
    output logic [4:0]  round,
    output logic        kn_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_ROUND = NUM_ROUNDS[4:0];

    state_t      state_q, state_d;
    logic [1:28] c_q, c_d;
    logic [1:28] d_q, d_d;
    logic [4:0]  round_q, round_d;
    logic        dir_q, dir_d;     // 1 = decrypt order
    logic        done_q, done_d;

    logic [1:56] pc1_out;
    logic        final_round;

    // PC-1 is needed only at load, so it is kept inline here rather than in its own module.
    always_comb begin
        pc1_out = '0;
        for (int i = 1; i <= 56; i++) begin
            pc1_out[i] = key[PC1[i]];
        end
    end

    // The last round to be consumed depends on the direction.
    assign final_round = dir_q ? (round_q == 5'd1) : (round_q == LAST_ROUND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // start outranks a simultaneous next. next while idle is simply dropped.
                if (start) begin
                    dir_d   = decrypt;
                    state_d = ACTIVE;
                    if (decrypt) begin
                        // C16||D16 equals C0||D0 because the total rotation is 28.
                        // So K16 needs no rotation.
                        c_d     = pc1_out[1:28];
                        d_d     = pc1_out[29:56];
                        round_d = LAST_ROUND;
                    end else begin
                        c_d     = rot_left(pc1_out[1:28], shift_amt(5'd1));
                        d_d     = rot_left(pc1_out[29:56], shift_amt(5'd1));
                        round_d = 5'd1;
                    end
                end
            end

            ACTIVE: begin
                // start while ACTIVE is deliberately ignored. Only rst abandons a schedule.
                if (next) begin
                    if (final_round) begin
                        // C and D are left as they are; their value no longer matters.
                        state_d = IDLE;
                        round_d = '0;
                        done_d  = 1'b1;
                    end else if (!dir_q) begin
                        // Encrypt: step to the next round, then apply that round's shift.
                        round_d = round_q + 5'd1;
                        c_d     = rot_left(c_q, shift_amt(round_q + 5'd1));
                        d_d     = rot_left(d_q, shift_amt(round_q + 5'd1));
                    end else begin
                        // Decrypt: undo the current round's shift, then step back one round.
                        round_d = round_q - 5'd1;
                        c_d     = rot_right(c_q, shift_amt(round_q));
                        d_d     = rot_right(d_q, shift_amt(round_q));
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    pc2_permutation u_pc2 (
        .data_i ({c_q, d_q}),
        .data_o (kn)
    );

    assign round    = round_q;
    assign kn_valid = (state_q == ACTIVE);
    assign busy     = (state_q == ACTIVE);
    assign done     = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:64] key;
    logic        decrypt;
    logic        next;
    logic [1:48] kn;
    logic [4:0]  round;
    logic        kn_valid;
    logic        busy;
    logic        done;

    int errors;
    int checks;

    localparam logic [63:0] REF_KEY    = 64'h133457799BBCDFF1;
    localparam logic [63:0] PARITY_KEY = 64'h0101010101010101;
    localparam logic [63:0] ONES_KEY   = 64'hFFFFFFFFFFFFFFFF;

    // Published subkeys for REF_KEY, K1..K16, worked out by hand from the DES tables.
    logic [47:0] kref [1:16];

    // kset selects the expected subkey set:
    //   0 = kref
    //   1 = all zero (the key has only parity bits set)
    //   2 = all ones
    typedef struct {
        logic [63:0] key;
        logic        decrypt;
        int          kset;
        int          hold_at;    // step at which next is held low for 5 cycles (0 = never)
        int          bad_at;     // step at which start is pulsed while active (0 = never)
        logic        chain;      // start the following vector in the done cycle
        logic        with_next;  // next is asserted together with start
    } vec_t;

    vec_t vecs [6];

    des_key_schedule #(.NUM_ROUNDS(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .decrypt  (decrypt),
        .next     (next),
        .kn       (kn),
        .round    (round),
        .kn_valid (kn_valid),
        .busy     (busy),
        .done     (done)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [47:0] exp_kn(input int kset, input int r);
        if (kset == 0) return kref[r];
        else if (kset == 1) return 48'h0;
        else return 48'hFFFFFFFFFFFF;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".kn_valid"}, 64'(kn_valid), 64'd0);
        check({tag, ".busy"},     64'(busy),     64'd0);
        check({tag, ".round"},    64'(round),    64'd0);
    endtask

    // Drive a start request. It is sampled on the next rising edge.
    task automatic drive_start(input logic [63:0] k, input logic dec, input logic with_next);
        start   = 1'b1;
        key     = k;
        decrypt = dec;
        next    = with_next;
    endtask

    // Entered at the negedge on which start is being driven.
    // Returns at a negedge: either the done cycle (when chaining) or the cycle after it.
    task automatic run_sched(input vec_t v, input int idx, input logic [63:0] nk, input logic nd);
        int    r;
        string tag;
        @(negedge clk);
        start = 1'b0;
        next  = 1'b0;
        for (int s = 1; s <= 16; s++) begin
            r   = v.decrypt ? 17 - s : s;
            tag = $sformatf("v%0d.s%0d", idx, s);
            check({tag, ".round"},    64'(round),    64'(r));
            check({tag, ".kn"},       64'(kn),       64'(exp_kn(v.kset, r)));
            check({tag, ".kn_valid"}, 64'(kn_valid), 64'd1);
            check({tag, ".busy"},     64'(busy),     64'd1);
            check({tag, ".done"},     64'(done),     64'd0);
            if (s == v.hold_at) begin
                next = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    @(negedge clk);
                    check({tag, ".hold_round"}, 64'(round),    64'(r));
                    check({tag, ".hold_kn"},    64'(kn),       64'(exp_kn(v.kset, r)));
                    check({tag, ".hold_valid"}, 64'(kn_valid), 64'd1);
                end
            end
            if (s == v.bad_at) begin
                // A restart with a different key and direction must be ignored.
                start   = 1'b1;
                key     = 64'h0;
                decrypt = ~v.decrypt;
            end
            next = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        next = 1'b0;
        tag  = $sformatf("v%0d.end", idx);
        check({tag, ".done"}, 64'(done), 64'd1);
        check_idle(tag);
        if (v.chain) begin
            drive_start(nk, nd, 1'b0);
        end else begin
            @(negedge clk);
            check({tag, ".done_low"}, 64'(done), 64'd0);
            check_idle({tag, ".after"});
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        key     = '0;
        decrypt = 1'b0;
        next    = 1'b0;

        kref = '{
            48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
            48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
            48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
            48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
        };

        vecs[0] = '{key: REF_KEY,    decrypt: 1'b0, kset: 0, hold_at: 7, bad_at: 0, chain: 1'b0, with_next: 1'b0};
        vecs[1] = '{key: REF_KEY,    decrypt: 1'b0, kset: 0, hold_at: 0, bad_at: 4, chain: 1'b1, with_next: 1'b0};
        vecs[2] = '{key: REF_KEY,    decrypt: 1'b1, kset: 0, hold_at: 0, bad_at: 0, chain: 1'b0, with_next: 1'b0};
        vecs[3] = '{key: PARITY_KEY, decrypt: 1'b0, kset: 1, hold_at: 0, bad_at: 0, chain: 1'b0, with_next: 1'b1};
        vecs[4] = '{key: ONES_KEY,   decrypt: 1'b1, kset: 2, hold_at: 0, bad_at: 0, chain: 1'b1, with_next: 1'b0};
        vecs[5] = '{key: REF_KEY,    decrypt: 1'b1, kset: 0, hold_at: 3, bad_at: 0, chain: 1'b0, with_next: 1'b0};

        // reset state
        repeat (2) @(negedge clk);
        check("rst.kn",   64'(kn),   64'd0);
        check("rst.done", 64'(done), 64'd0);
        check_idle("rst");
        rst = 1'b0;

        // next while idle: no effect
        next = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("idle_next");
            check("idle_next.kn",   64'(kn),   64'd0);
            check("idle_next.done", 64'(done), 64'd0);
        end
        next = 1'b0;

        // table-driven schedules
        for (int i = 0; i < 6; i++) begin
            if (!(i > 0 && vecs[i-1].chain)) begin
                @(negedge clk);
                drive_start(vecs[i].key, vecs[i].decrypt, vecs[i].with_next);
            end
            if (i < 5) begin
                run_sched(vecs[i], i, vecs[i+1].key, vecs[i+1].decrypt);
            end else begin
                run_sched(vecs[i], i, 64'h0, 1'b0);
            end
        end

        // asynchronous reset in the middle of a schedule
        @(negedge clk);
        drive_start(REF_KEY, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("mid.round1", 64'(round), 64'd1);
        next = 1'b1;
        repeat (9) @(negedge clk);
        next = 1'b0;
        check("mid.round10", 64'(round), 64'd10);
        check("mid.kn10",    64'(kn),    64'(kref[10]));
        #2 rst = 1'b1;
        #1;
        check("mid_rst.kn",   64'(kn),   64'd0);
        check("mid_rst.done", 64'(done), 64'd0);
        check_idle("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        drive_start(REF_KEY, 1'b0, 1'b0);
        run_sched(vecs[0], 9, 64'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
